// File: rtl/conv_frame_writer.sv
// -----------------------------------------------------------------------------
// conv_frame_writer
//
// Consumer end of the convolution pixel stream. Pixel beats (in_valid == 2'b01)
// arrive in bottom-left to top-right raster order. Each accepted beat is tagged
// with its frame-buffer address (row*IMAGE_WIDTH + col) and buffered in a small
// first-word-fall-through FIFO. The FIFO drains into a frame-memory write port
// that may apply backpressure. frame_done pulses once the frame is fully written.
//
// Optional feature (compile-time macro CONV_WRITER_CHECKSUM_EN):
//   adds output checksum[15:0], a wrapping 16-bit sum of wr_data over every
//   write handshake. Cleared on reset and on the start that enters RUN.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   one-cycle pulse, arms capture of one frame (IDLE only)
//   in_pixel    in   pixel data from the convolution stage
//   in_valid    in   beat code; only 2'b01 carries a pixel
//   wr_en       out  write request (FIFO non-empty)
//   wr_addr     out  write address (FIFO head, zero when empty)
//   wr_data     out  write data    (FIFO head, zero when empty)
//   wr_ready    in   frame memory accepts the write this cycle
//   busy        out  high in RUN or DRAIN
//   frame_done  out  one-cycle pulse at frame completion
//   overflow    out  sticky, a beat was dropped on a full FIFO
//   checksum    out  (CONV_WRITER_CHECKSUM_EN only) running write-data sum
// -----------------------------------------------------------------------------
module conv_frame_writer #(
    parameter int WORD_SIZE    = 8,
    parameter int IMAGE_WIDTH  = 540,
    parameter int IMAGE_HEIGHT = 360,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_SIZE-1:0]  in_pixel,
    input  logic [1:0]            in_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_SIZE-1:0]  wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
`ifdef CONV_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [ROW_W-1:0] row_q,      row_d;
    logic [COL_W-1:0] col_q,      col_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overflow_q, overflow_d;
`ifdef CONV_WRITER_CHECKSUM_EN
    logic [15:0]      checksum_q, checksum_d;
`endif

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]  mem_data [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Beat qualification and FIFO handshakes
    // ------------------------------------------------------------------
    logic                  pixel_beat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  pop;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WORD_SIZE-1:0]  head_data;

    assign pixel_beat = (in_valid == 2'b01);
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    // Fullness is judged on the registered count, so a beat arriving on a
    // full FIFO is dropped even if the head drains on the same edge.
    assign accept     = (state_q == ST_RUN) && pixel_beat && !fifo_full;
    assign pop        = !fifo_empty && wr_ready;
    assign last_beat  = (row_q == '0) && (col_q == COL_LAST);
    assign beat_addr  = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(IMAGE_WIDTH) + ADDR_WIDTH'(col_q);
    assign head_addr  = mem_addr[rd_ptr_q];
    assign head_data  = mem_data[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO pointer / occupancy next-state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame control: FSM, raster counters, sticky overflow, checksum
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        overflow_d = overflow_q;
`ifdef CONV_WRITER_CHECKSUM_EN
        checksum_d = checksum_q;
        if (pop) checksum_d = checksum_q + 16'(head_data);
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    row_d      = ROW_LAST;
                    col_d      = '0;
                    overflow_d = 1'b0;
`ifdef CONV_WRITER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (pixel_beat && fifo_full) overflow_d = 1'b1;
                if (accept) begin
                    // Row decrements past 0 after the last beat; harmless,
                    // since the counters are reloaded by the next start.
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q - ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_beat) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the final write handshakes, so frame_done
                // follows the last write by exactly one cycle.
                if (count_d == '0) state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            state_q    <= ST_IDLE;
            row_q      <= ROW_LAST;
            col_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef CONV_WRITER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef CONV_WRITER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: storage has no reset; the pointers and count are reset instead,
    // and the outputs are gated to zero while the FIFO is empty, so stale
    // entries can never reach the write port.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_addr[wr_ptr_q] <= beat_addr;
            mem_data[wr_ptr_q] <= in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_en      = !fifo_empty;
    assign wr_addr    = fifo_empty ? '0 : head_addr;
    assign wr_data    = fifo_empty ? '0 : head_data;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign frame_done = (state_q == ST_DONE);
    assign overflow   = overflow_q;
`ifdef CONV_WRITER_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_conv_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_conv_frame_writer
//
// Directed self-checking bench for conv_frame_writer with a 4x3 image and a
// 4-entry FIFO. A negedge monitor records every write handshake, frame_done
// pulses and stall stability; scenarios compare against hand-computed tables.
// -----------------------------------------------------------------------------
module tb_conv_frame_writer;

    localparam int WORD_SIZE    = 8;
    localparam int IMAGE_WIDTH  = 4;
    localparam int IMAGE_HEIGHT = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int ADDR_WIDTH   = 8;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b0;
    logic                  start    = 1'b0;
    logic [WORD_SIZE-1:0]  in_pixel = '0;
    logic [1:0]            in_valid = 2'b00;
    logic                  wr_ready = 1'b1;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_SIZE-1:0]  wr_data;
    logic                  busy;
    logic                  frame_done;
    logic                  overflow;
`ifdef CONV_WRITER_CHECKSUM_EN
    logic [15:0]           checksum;
    logic [15:0]           done_ck = '0;
`endif

    conv_frame_writer #(
        .WORD_SIZE    (WORD_SIZE),
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef CONV_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Expected raster addresses for a 4x3 frame, bottom row first.
    int exp_addr [12] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor (sole writer of the recorded history)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] got_addr [$];
    logic [WORD_SIZE-1:0]  got_data [$];
    int cyc         = 0;
    int last_hs_cyc = 0;
    int done_cyc    = 0;
    int done_cnt    = 0;
    int stall_seen  = 0;
    int stall_break = 0;
    logic                  prev_stall = 1'b0;
    logic [ADDR_WIDTH-1:0] prev_addr  = '0;
    logic [WORD_SIZE-1:0]  prev_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                stall_seen++;
                if (wr_addr !== prev_addr || wr_data !== prev_data) stall_break++;
            end
            if (wr_en && wr_ready) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
                last_hs_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef CONV_WRITER_CHECKSUM_EN
                done_ck = checksum;
`endif
            end
        end
        prev_stall = rst && wr_en && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WORD_SIZE-1:0] data, input logic [1:0] code);
        in_pixel = data;
        in_valid = code;
        tick();
        in_valid = 2'b00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int max_cycles);
        int n = 0;
        while (done_cnt < target && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt >= target), 1);
    endtask

    task automatic check_frame(input string tag, input int base);
        check({tag, "_count"}, got_addr.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            if (base + i < got_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), got_addr[base + i], exp_addr[i]);
                check($sformatf("%s_data%0d", tag, i), got_data[base + i], i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        int base;
        int dbase;
        int sbase;
        int bbase;

        // Reset state
        tick();
        tick();
        check("rst_wr_en",   wr_en,      0);
        check("rst_wr_addr", wr_addr,    0);
        check("rst_wr_data", wr_data,    0);
        check("rst_busy",    busy,       0);
        check("rst_done",    frame_done, 0);
        check("rst_ovf",     overflow,   0);
        rst = 1'b1;
        tick();

        // 1. Basic frame
        base  = got_addr.size();
        dbase = done_cnt;
        pulse_start();
        check("s1_busy", busy, 1);
        for (int i = 0; i < 12; i++) beat(8'(i), 2'b01);
        wait_done("s1_done_seen", dbase + 1, 50);
        tick();
        tick();
        check_frame("s1", base);
        check("s1_done_cnt", done_cnt - dbase, 1);
        check("s1_done_lat", done_cyc - last_hs_cyc, 1);
        check("s1_ovf", overflow, 0);
        check("s1_busy_end", busy, 0);

        // 2. Backpressure: beats every other cycle, wr_ready low for cycles 3-5
        base  = got_addr.size();
        dbase = done_cnt;
        sbase = stall_seen;
        bbase = stall_break;
        pulse_start();
        for (int k = 0; k < 24; k++) begin
            wr_ready = !(k >= 3 && k <= 5);
            in_pixel = 8'(k / 2);
            in_valid = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick();
        end
        in_valid = 2'b00;
        wr_ready = 1'b1;
        wait_done("s2_done_seen", dbase + 1, 50);
        tick();
        check_frame("s2", base);
        check("s2_stalled", 32'(stall_seen > sbase), 1);
        check("s2_stable", stall_break - bbase, 0);
        check("s2_ovf", overflow, 0);

        // 3. Overflow, plus a start in RUN that must be ignored
        base     = got_addr.size();
        dbase    = done_cnt;
        wr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) beat(8'(8'hA0 + i), 2'b01);
        tick();
        check("s3_ovf", overflow, 1);
        check("s3_no_writes", got_addr.size() - base, 0);
        pulse_start();
        check("s3_ovf_kept", overflow, 1);
        check("s3_busy", busy, 1);
        wr_ready = 1'b1;
        repeat (8) tick();
        check("s3_writes", got_addr.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < got_addr.size()) begin
                check($sformatf("s3_addr%0d", i), got_addr[base + i], 8 + i);
                check($sformatf("s3_data%0d", i), got_data[base + i], 8'hA0 + i);
            end
        end
        base = got_addr.size();
        for (int i = 0; i < 8; i++) beat(8'(8'hB0 + i), 2'b01);
        wait_done("s3_done_seen", dbase + 1, 50);
        tick();
        check("s3_rest_count", got_addr.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < got_addr.size()) begin
                check($sformatf("s3_rest_addr%0d", i), got_addr[base + i], exp_addr[4 + i]);
                check($sformatf("s3_rest_data%0d", i), got_data[base + i], 8'hB0 + i);
            end
        end
        check("s3_ovf_sticky", overflow, 1);
        check("s3_done_cnt", done_cnt - dbase, 1);

        // 4. Invalid codes interleaved; pixel beat in IDLE ignored
        base = got_addr.size();
        beat(8'h55, 2'b01);
        repeat (3) tick();
        check("s4_idle_ignored", got_addr.size() - base, 0);
        dbase = done_cnt;
        pulse_start();
        check("s4_ovf_clr", overflow, 0);
        for (int i = 0; i < 12; i++) begin
            beat(8'hE0, 2'b00);
            beat(8'(i), 2'b01);
            beat(8'hE1, 2'b10);
            beat(8'hE2, 2'b11);
        end
        wait_done("s4_done_seen", dbase + 1, 50);
        tick();
        check_frame("s4", base);
        check("s4_done_cnt", done_cnt - dbase, 1);

        // 5. Reset mid-frame, then a clean frame
        dbase = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) beat(8'(i), 2'b01);
        check("s5_pre_wr_en", wr_en, 1);
        #1 rst = 1'b0;
        #1;
        check("s5_rst_wr_en",   wr_en,      0);
        check("s5_rst_wr_addr", wr_addr,    0);
        check("s5_rst_wr_data", wr_data,    0);
        check("s5_rst_busy",    busy,       0);
        check("s5_rst_done",    frame_done, 0);
        check("s5_rst_ovf",     overflow,   0);
        tick();
        tick();
        rst = 1'b1;
        repeat (10) tick();
        check("s5_no_done", done_cnt - dbase, 0);
        check("s5_idle", busy, 0);
        base  = got_addr.size();
        dbase = done_cnt;
        pulse_start();
        for (int i = 0; i < 12; i++) beat(8'(i), 2'b01);
        wait_done("s5_done_seen", dbase + 1, 50);
        tick();
        check_frame("s5", base);
        check("s5_done_cnt", done_cnt - dbase, 1);

`ifdef CONV_WRITER_CHECKSUM_EN
        // 6. Checksum: previous frame summed to 0x0042, so the clear is visible
        check("s6_ck_prev", checksum, 16'h0042);
        dbase = done_cnt;
        pulse_start();
        check("s6_ck_clr", checksum, 16'h0000);
        for (int i = 0; i < 12; i++) beat(8'hFF, 2'b01);
        wait_done("s6_done_seen", dbase + 1, 50);
        check("s6_ck_done", done_ck, 16'h0BF4);
        repeat (3) tick();
        check("s6_ck_hold", checksum, 16'h0BF4);
        pulse_start();
        check("s6_ck_restart", checksum, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
